// File: rtl/uart_io_pkg.sv
// Shared state encodings and 8N1 frame constants for the
// flat-I/O UART wrapper and its transmit serializer.
package uart_io_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        PRESENT,
        AWAIT,
        TRANSMIT
    } io_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    localparam int unsigned DataBits  = 8;
    localparam int unsigned StopBits  = 1;
    localparam int unsigned FrameBits = 1 + DataBits + StopBits;

endpackage

// File: rtl/uart_tx_serializer.sv
// Bit-serial 8N1 transmitter: takes one byte per valid/ready
// handshake and shifts start, data (LSB first) and stop bits out.
module uart_tx_serializer
    import uart_io_pkg::*;
#(
    parameter int unsigned ClocksPerBaud = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DataBits-1:0] tx_byte,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx_out
);

    localparam int unsigned BaudW = $clog2(ClocksPerBaud);
    localparam int unsigned BitW  = $clog2(FrameBits);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClocksPerBaud - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(FrameBits - 1);

    logic [FrameBits-1:0] shreg;
    logic [BaudW-1:0]     baud_cnt;
    logic [BitW-1:0]      bits_left;
    logic                 busy;
    logic                 bit_end;

    assign bit_end = (baud_cnt == '0);
    // Ready during the final stop-bit cycle keeps bytes back-to-back.
    assign tx_ready = !busy || (bit_end && (bits_left == '0));
    assign tx_out   = shreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '1;
            baud_cnt  <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            shreg     <= {{StopBits{1'b1}}, tx_byte, 1'b0};
            baud_cnt  <= BaudLast;
            bits_left <= BitLast;
            busy      <= 1'b1;
        end else if (busy) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else if (bits_left == '0) begin
                busy <= 1'b0;
            end else begin
                shreg     <= {1'b1, shreg[FrameBits-1:1]};
                bits_left <= bits_left - 1'b1;
                baud_cnt  <= BaudLast;
            end
        end
    end

endmodule

// File: rtl/uart_flat_io_wrapper.sv
// UART front end for a compute block: gathers rx bytes into a flat
// input frame, hands it off, then serializes the flat result frame.
module uart_flat_io_wrapper
    import uart_io_pkg::*;
#(
    parameter int unsigned ClocksPerBaud = 8,
    parameter int unsigned InputBytes    = 1,
    parameter int unsigned OutputBytes   = 4,
    parameter int unsigned TimeoutBauds  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_in,
    output logic                     tx_out,
    output logic                     clear_to_send_out_n,
    output logic [8*InputBytes-1:0]  flat_input,
    output logic                     flat_input_valid,
    input  logic                     flat_input_ready,
    input  logic [8*OutputBytes-1:0] flat_output,
    input  logic                     flat_output_valid,
    output logic                     flat_output_ready,
    output logic                     rx_error,
    output logic                     rx_timeout
);

    localparam int unsigned BaudW     = $clog2(ClocksPerBaud);
    localparam int unsigned RxBitW    = $clog2(DataBits);
    localparam int unsigned CntW      = $clog2(InputBytes + 1);
    localparam int unsigned OIdxW     = $clog2(OutputBytes + 1);
    localparam int unsigned TmoCycles = TimeoutBauds * ClocksPerBaud;
    localparam int unsigned TmoW      =
        (TmoCycles > 0) ? $clog2(TmoCycles + 1) : 1;

    localparam logic [BaudW-1:0]  BaudLast  = BaudW'(ClocksPerBaud - 1);
    localparam logic [BaudW-1:0]  BaudHalf  = BaudW'(ClocksPerBaud / 2 - 1);
    localparam logic [RxBitW-1:0] RxBitLast = RxBitW'(DataBits - 1);
    localparam logic [CntW-1:0]   CntLast   = CntW'(InputBytes - 1);
    localparam logic [OIdxW-1:0]  OIdxEnd   = OIdxW'(OutputBytes);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TmoCycles - 1);

    logic rx_s1, rx_sync;

    rx_state_t           rx_st, rx_st_d;
    logic [BaudW-1:0]    rx_baud, rx_baud_d;
    logic [RxBitW-1:0]   rx_bits, rx_bits_d;
    logic [DataBits-1:0] rx_shift, rx_shift_d;
    logic                rx_done, rx_ferr;

    io_state_t               state, state_d;
    logic [CntW-1:0]         byte_cnt;
    logic [TmoW-1:0]         tmo_cnt;
    logic [8*OutputBytes-1:0] out_reg;
    logic [OIdxW-1:0]        out_idx;
    logic                    store, last_in, tmo_run, tmo_fire;

    logic [DataBits-1:0] tx_byte;
    logic                tx_valid, tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_sync <= rx_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st    <= RX_IDLE;
            rx_baud  <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            rx_st    <= rx_st_d;
            rx_baud  <= rx_baud_d;
            rx_bits  <= rx_bits_d;
            rx_shift <= rx_shift_d;
        end
    end

    always_comb begin
        rx_st_d    = rx_st;
        rx_baud_d  = rx_baud;
        rx_bits_d  = rx_bits;
        rx_shift_d = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_st)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_st_d   = RX_START;
                    rx_baud_d = BaudHalf;
                end
            end
            RX_START: begin
                if (rx_baud != '0) begin
                    rx_baud_d = rx_baud - 1'b1;
                end else if (rx_sync) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_st_d   = RX_DATA;
                    rx_baud_d = BaudLast;
                    rx_bits_d = '0;
                end
            end
            RX_DATA: begin
                if (rx_baud != '0) begin
                    rx_baud_d = rx_baud - 1'b1;
                end else begin
                    rx_shift_d = {rx_sync, rx_shift[DataBits-1:1]};
                    rx_baud_d  = BaudLast;
                    if (rx_bits == RxBitLast) rx_st_d = RX_STOP;
                    else rx_bits_d = rx_bits + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_baud != '0) begin
                    rx_baud_d = rx_baud - 1'b1;
                end else if (rx_sync) begin
                    rx_done = 1'b1;
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_ferr = 1'b1;
                    rx_st_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (rx_sync) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    assign store    = rx_done && (state == COLLECT);
    assign last_in  = (byte_cnt == CntLast);
    // Idle time only accrues while a partial frame waits on a quiet line.
    assign tmo_run  = (TimeoutBauds != 0) && (state == COLLECT) &&
                      (byte_cnt != '0) && (rx_st == RX_IDLE) && rx_sync;
    assign tmo_fire = tmo_run && (tmo_cnt == TmoLast);

    always_comb begin
        state_d             = state;
        clear_to_send_out_n = 1'b1;
        flat_input_valid    = 1'b0;
        flat_output_ready   = 1'b0;
        tx_valid            = 1'b0;
        unique case (state)
            COLLECT: begin
                clear_to_send_out_n = 1'b0;
                if (store && last_in) state_d = PRESENT;
            end
            PRESENT: begin
                flat_input_valid = 1'b1;
                if (flat_input_ready) state_d = AWAIT;
            end
            AWAIT: begin
                flat_output_ready = 1'b1;
                if (flat_output_valid) state_d = TRANSMIT;
            end
            TRANSMIT: begin
                tx_valid = (out_idx != OIdxEnd);
                if (!tx_valid && tx_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        tx_byte = '0;
        for (int j = 0; j < OutputBytes; j++) begin
            if (out_idx == OIdxW'(j)) tx_byte = out_reg[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            flat_input <= '0;
            out_reg    <= '0;
            out_idx    <= '0;
            rx_error   <= 1'b0;
            rx_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            rx_error   <= rx_ferr && (state == COLLECT);
            rx_timeout <= tmo_fire;
            if (store) begin
                for (int i = 0; i < InputBytes; i++) begin
                    if (byte_cnt == CntW'(i)) flat_input[8*i +: 8] <= rx_shift;
                end
                byte_cnt <= last_in ? '0 : byte_cnt + 1'b1;
            end else if (tmo_fire) begin
                byte_cnt <= '0;
            end
            if (tmo_run && !tmo_fire) tmo_cnt <= tmo_cnt + 1'b1;
            else tmo_cnt <= '0;
            if ((state == AWAIT) && flat_output_valid) begin
                out_reg <= flat_output;
                out_idx <= '0;
            end else if (tx_valid && tx_ready) begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

    uart_tx_serializer #(
        .ClocksPerBaud(ClocksPerBaud)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_byte (tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out)
    );

endmodule

// File: tb/tb_uart_flat_io_wrapper.sv
// Directed scoreboard bench for the flat UART wrapper
// (8 clocks/baud, 2 bytes in, 4 bytes out, 4-baud timeout).
module tb_uart_flat_io_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_in;
    logic        tx_out;
    logic        clear_to_send_out_n;
    logic [15:0] flat_input;
    logic        flat_input_valid;
    logic        flat_input_ready;
    logic [31:0] flat_output;
    logic        flat_output_valid;
    logic        flat_output_ready;
    logic        rx_error;
    logic        rx_timeout;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_in_q[$];
    logic [7:0]  exp_tx_q[$];

    int err_pulses = 0;
    int tmo_pulses = 0;
    int err_len    = 0;
    int tmo_len    = 0;
    int tx_seen    = 0;
    int tx_starts  = 0;
    int tx_target  = 0;
    int tx_ph      = 0;
    int tx_cyc     = 0;
    int snap       = 0;
    logic [7:0] tx_b = '0;
    logic in_prev = 1'b0;

    uart_flat_io_wrapper #(
        .ClocksPerBaud(8),
        .InputBytes   (2),
        .OutputBytes  (4),
        .TimeoutBauds (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_in              (rx_in),
        .tx_out             (tx_out),
        .clear_to_send_out_n(clear_to_send_out_n),
        .flat_input         (flat_input),
        .flat_input_valid   (flat_input_valid),
        .flat_input_ready   (flat_input_ready),
        .flat_output        (flat_output),
        .flat_output_valid  (flat_output_valid),
        .flat_output_ready  (flat_output_ready),
        .rx_error           (rx_error),
        .rx_timeout         (rx_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return flat_input_valid;
            1: return flat_output_ready;
            2: return !clear_to_send_out_n;
            default: return tx_seen >= tx_target;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w,
                            input int maxc);
        int n = 0;
        while (!sig(w) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, sig(w), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (8) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic accept_input();
        flat_input_ready = 1'b1;
        @(negedge clk);
        flat_input_ready = 1'b0;
    endtask

    task automatic give_output(input logic [31:0] v, input int n);
        wait_for("out_ready", 1, 20);
        for (int j = 0; j < n; j++) exp_tx_q.push_back(v[8*j +: 8]);
        flat_output       = v;
        flat_output_valid = 1'b1;
        @(negedge clk);
        flat_output_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [31:0] v);
        accept_input();
        give_output(v, 4);
        wait_for("cts_low", 2, 400);
        check("tx_drained", exp_tx_q.size(), 0);
    endtask

    // Input-frame monitor: one compare per rising flat_input_valid.
    initial forever begin
        @(negedge clk);
        if (flat_input_valid && !in_prev) begin
            if (exp_in_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL in_unexpected: frame %h", flat_input);
            end else begin
                check("in_frame", flat_input, exp_in_q.pop_front());
            end
        end
        in_prev = flat_input_valid;
    end

    // UART decoder on tx_out, abandons a byte cut by reset.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            tx_ph = 0;
        end else if (tx_ph == 0) begin
            if (!tx_out) begin
                tx_ph = 1;
                tx_cyc = 0;
                tx_starts++;
            end
        end else begin
            tx_cyc++;
            if (tx_cyc >= 12 && tx_cyc <= 68 && tx_cyc % 8 == 4)
                tx_b[(tx_cyc - 12) / 8] = tx_out;
            if (tx_cyc == 76) begin
                tx_ph = 0;
                check("tx_stop", tx_out, 1);
                if (exp_tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: byte %h", tx_b);
                end else begin
                    check("tx_byte", tx_b, exp_tx_q.pop_front());
                end
                tx_seen++;
            end
        end
    end

    // Pulse counters with single-cycle width checks.
    initial forever begin
        @(negedge clk);
        if (rx_error) begin
            if (err_len == 0) err_pulses++;
            err_len++;
        end else if (err_len != 0) begin
            check("rx_error_width", err_len, 1);
            err_len = 0;
        end
        if (rx_timeout) begin
            if (tmo_len == 0) tmo_pulses++;
            tmo_len++;
        end else if (tmo_len != 0) begin
            check("rx_timeout_width", tmo_len, 1);
            tmo_len = 0;
        end
    end

    initial begin
        repeat (60000) @(negedge clk);
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        rx_in             = 1'b1;
        flat_input_ready  = 1'b0;
        flat_output_valid = 1'b0;
        flat_output       = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_cts_n", clear_to_send_out_n, 0);
        check("rst_in_valid", flat_input_valid, 0);
        check("rst_out_ready", flat_output_ready, 0);
        check("rst_rx_error", rx_error, 0);
        check("rst_rx_timeout", rx_timeout, 0);
        check("rst_flat_input", flat_input, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame in, result out.
        exp_in_q.push_back(16'hA355);
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        wait_for("in_valid_1", 0, 20);
        check("cts_n_present", clear_to_send_out_n, 1);
        finish_frame(32'h56575859);

        // Stalled handshake with a stray byte on the line.
        exp_in_q.push_back(16'h1234);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_for("in_valid_2", 0, 20);
        fork
            send_byte(8'h99, 1'b1);
            repeat (100) begin
                @(negedge clk);
                check("hold", {clear_to_send_out_n, flat_input_valid,
                               flat_input}, {2'b11, 16'h1234});
            end
        join
        check("no_err_outside", err_pulses, 0);
        finish_frame(32'h0F1E2D3C);

        // Framing error then a clean frame.
        send_byte(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        check("rx_error_count", err_pulses, 1);
        exp_in_q.push_back(16'h2211);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_for("in_valid_3", 0, 20);
        finish_frame(32'h89ABCDEF);

        // Partial-frame timeout.
        send_byte(8'h77, 1'b1);
        repeat (40) @(negedge clk);
        check("rx_timeout_count", tmo_pulses, 1);
        exp_in_q.push_back(16'h0201);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_for("in_valid_4", 0, 20);

        // Reset during output byte 2.
        accept_input();
        tx_target = tx_seen + 2;
        give_output(32'hA1B2C3D4, 2);
        wait_for("tx_two_bytes", 3, 400);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_out", tx_out, 1);
        check("midrst_cts_n", clear_to_send_out_n, 0);
        repeat (3) @(negedge clk);
        check("midrst_flat_input", flat_input, 0);
        rst_n = 1'b1;
        snap = tx_starts;
        repeat (300) @(negedge clk);
        check("no_tx_after_rst", tx_starts, snap);
        check("cts_n_after_rst", clear_to_send_out_n, 0);
        check("tx_q_after_rst", exp_tx_q.size(), 0);

        // Short glitch on an idle line.
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_err", err_pulses, 1);
        check("glitch_tmo", tmo_pulses, 1);
        check("glitch_valid", flat_input_valid, 0);
        exp_in_q.push_back(16'hCDAB);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        wait_for("in_valid_5", 0, 20);
        finish_frame(32'h11223344);

        check("in_drained", exp_in_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
